// File: rtl/step_autorepeat_if.sv
// Button-side bundle for step_autorepeat: timing strobe and debounced
// level in, step pulse and hold/repeat status out.
interface step_autorepeat_if;
  logic tick;
  logic level;
  logic step;
  logic held;
  logic repeating;

  modport master (
    output tick,
    output level,
    input  step,
    input  held,
    input  repeating
  );

  modport slave (
    input  tick,
    input  level,
    output step,
    output held,
    output repeating
  );
endinterface

// File: rtl/step_autorepeat.sv
// Turns a held step button into a press pulse followed by auto-repeat
// pulses, timed in tick strobes on the fast system clock.
module step_autorepeat #(
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int CNT_BITS     = 10
) (
  input  logic       clock,
  input  logic       reset,
  step_autorepeat_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  localparam logic [CNT_BITS-1:0] HOLD_LAST =
    CNT_BITS'(HOLD_TICKS - 1);
  localparam logic [CNT_BITS-1:0] REP_LAST =
    CNT_BITS'(REPEAT_TICKS - 1);

  logic                s1;
  logic                s2;
  state_t              state;
  state_t              state_n;
  logic [CNT_BITS-1:0] cnt;
  logic [CNT_BITS-1:0] cnt_n;
  logic                step_n;
  logic                step_q;
  logic                held_q;
  logic                rep_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      state  <= IDLE;
      cnt    <= '0;
      step_q <= 1'b0;
      held_q <= 1'b0;
      rep_q  <= 1'b0;
    end else begin
      s1     <= bus.level;
      s2     <= s1;
      state  <= state_n;
      cnt    <= cnt_n;
      step_q <= step_n;
      held_q <= (state_n != IDLE);
      rep_q  <= (state_n == REPEAT);
    end
  end

  // Release is checked before tick so a coincident expiry never pulses.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    step_n  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (s2) begin
          state_n = HOLD;
          step_n  = 1'b1;
        end
      end
      HOLD: begin
        if (!s2) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (bus.tick) begin
          if (cnt == HOLD_LAST) begin
            state_n = REPEAT;
            step_n  = 1'b1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      REPEAT: begin
        if (!s2) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (bus.tick) begin
          if (cnt == REP_LAST) begin
            step_n = 1'b1;
            cnt_n  = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign bus.step      = step_q;
  assign bus.held      = held_q;
  assign bus.repeating = rep_q;

endmodule

// File: tb/tb_step_autorepeat.sv
// Directed bench for step_autorepeat: press, hold, repeat, release race,
// reset mid-repeat and the one-tick interval corner.
module tb_step_autorepeat;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  step_autorepeat_if ifa ();
  step_autorepeat_if ifb ();

  step_autorepeat #(
    .HOLD_TICKS  (3),
    .REPEAT_TICKS(2),
    .CNT_BITS    (4)
  ) dut_a (
    .clock(clock),
    .reset(reset),
    .bus  (ifa.slave)
  );

  step_autorepeat #(
    .HOLD_TICKS  (1),
    .REPEAT_TICKS(1),
    .CNT_BITS    (2)
  ) dut_b (
    .clock(clock),
    .reset(reset),
    .bus  (ifb.slave)
  );

  int   nvec = 0;
  int   nerr = 0;
  int   npulse;
  logic st [0:63];
  logic hd [0:63];
  logic rp [0:63];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // Slot c: sample outputs of the previous edge, then drive inputs
  // for the next edge. Level is high for c < rel; tick when c%4 == ph.
  task automatic run(input int n, input int rel,
                     input int ph, input bit sel);
    npulse = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      st[c] = sel ? ifb.step      : ifa.step;
      hd[c] = sel ? ifb.held      : ifa.held;
      rp[c] = sel ? ifb.repeating : ifa.repeating;
      if (st[c]) npulse++;
      ifa.level = !sel && (c < rel);
      ifb.level =  sel && (c < rel);
      ifa.tick  = !sel && (c % 4 == ph);
      ifb.tick  =  sel && (c % 4 == ph);
    end
  endtask

  initial begin
    reset     = 1'b1;
    ifa.level = 1'b0;
    ifa.tick  = 1'b0;
    ifb.level = 1'b0;
    ifb.tick  = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_step", ifa.step, 0);
    chk("rst_held", ifa.held, 0);
    reset = 1'b0;

    run(10, 0, 3, 0);
    chk("idle_pulses", npulse, 0);
    chk("idle_held", hd[9], 0);

    run(16, 8, 3, 0);
    chk("short_pulses", npulse, 1);
    chk("short_st2", st[2], 0);
    chk("short_st3", st[3], 1);
    chk("short_st4", st[4], 0);
    chk("short_hd3", hd[3], 1);
    chk("short_hd10", hd[10], 1);
    chk("short_hd11", hd[11], 0);

    run(48, 40, 3, 0);
    chk("long_pulses", npulse, 5);
    chk("long_st3", st[3], 1);
    chk("long_st11", st[11], 0);
    chk("long_st12", st[12], 1);
    chk("long_st20", st[20], 1);
    chk("long_st36", st[36], 1);
    chk("long_rp11", rp[11], 0);
    chk("long_rp12", rp[12], 1);
    chk("long_hd42", hd[42], 1);
    chk("long_hd43", hd[43], 0);
    chk("long_rp43", rp[43], 0);

    run(20, 9, 3, 0);
    chk("race_pulses", npulse, 1);
    chk("race_st12", st[12], 0);
    chk("race_hd11", hd[11], 1);
    chk("race_hd12", hd[12], 0);

    run(12, 100, 3, 0);
    @(posedge clock);
    #2;
    chk("pre_rst_step", ifa.step, 1);
    chk("pre_rst_rep", ifa.repeating, 1);
    reset = 1'b1;
    #1;
    chk("async_step", ifa.step, 0);
    chk("async_held", ifa.held, 0);
    chk("async_rep", ifa.repeating, 0);
    @(negedge clock);
    ifa.tick = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b0;
    run(16, 16, 3, 0);
    chk("rel_st2", st[2], 0);
    chk("rel_st3", st[3], 1);
    chk("rel_hd3", hd[3], 1);
    chk("rel_st11", st[11], 0);
    chk("rel_st12", st[12], 1);
    chk("rel_rp12", rp[12], 1);
    chk("rel_pulses", npulse, 2);
    run(8, 0, 3, 0);
    chk("rel_idle", hd[7], 0);

    run(24, 18, 1, 1);
    chk("one_pulses", npulse, 5);
    chk("one_st3", st[3], 1);
    chk("one_st4", st[4], 0);
    chk("one_st6", st[6], 1);
    chk("one_st7", st[7], 0);
    chk("one_rp6", rp[6], 1);
    chk("one_st18", st[18], 1);
    chk("one_hd20", hd[20], 1);
    chk("one_hd21", hd[21], 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
